// File: rtl/pipeline.sv
// pipeline: core-wide constants shared by pipeline-facing blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipeline;
  localparam int XLEN = 32;
endpackage

// File: rtl/c2c_r_arb.sv
// c2c_r_arb: round-robin N-way arbiter, core read masters onto one cache read port.
// Latency: m_re -> s_re 1 cycle; s_ack -> m_ack same cycle (1 cycle with the response register).
// Backpressure: one read outstanding; the grant holds until s_ack, losers wait holding re.
// Optional feature macro: C2C_R_ARB_RSP_REG_EN adds a registered response stage (RESP state).
module c2c_r_arb #(
  parameter int XLEN    = pipeline::XLEN,
  parameter int N_PORTS = 2,
  parameter int GW      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        m_re,
  input  logic [N_PORTS*XLEN/8-1:0] m_sel,
  input  logic [N_PORTS*XLEN-1:0]   m_addr,
  output logic [N_PORTS-1:0]        m_ack,
  output logic [N_PORTS*XLEN-1:0]   m_data,
  output logic                      s_re,
  output logic [XLEN/8-1:0]         s_sel,
  output logic [XLEN-1:0]           s_addr,
  input  logic                      s_ack,
  input  logic [XLEN-1:0]           s_data
);

  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last_grant;
  logic [SW-1:0]   sel_q;
  logic [XLEN-1:0] addr_q;

  logic            pick_vld;
  logic [GW-1:0]   pick_idx;
  logic [SW-1:0]   pick_sel;
  logic [XLEN-1:0] pick_addr;

  logic            rsp_fire;
  logic [XLEN-1:0] rsp_dat;

`ifdef C2C_R_ARB_RSP_REG_EN
  logic [XLEN-1:0] rsp_data_q;
`endif

  // Round-robin pick: lowest requester above last_grant, else wrap to lowest requester overall
  always_comb begin
    logic          hi_any;
    logic [GW-1:0] hi_idx;
    logic [GW-1:0] lo_idx;
    hi_any    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    pick_vld  = 1'b0;
    pick_idx  = '0;
    pick_sel  = '0;
    pick_addr = '0;
    // Descending scan so the last hit written is the lowest index
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (m_re[i]) begin
        pick_vld = 1'b1;
        lo_idx   = GW'(i);
        if (i > int'(last_grant)) begin
          hi_any = 1'b1;
          hi_idx = GW'(i);
        end
      end
    end
    pick_idx = hi_any ? hi_idx : lo_idx;
    for (int i = 0; i < N_PORTS; i++) begin
      if (GW'(i) == pick_idx) begin
        pick_sel  = m_sel[i*SW +: SW];
        pick_addr = m_addr[i*XLEN +: XLEN];
      end
    end
  end

  // Control FSM: latch the winner in IDLE, hold the request in BUSY until the slave acks
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(N_PORTS - 1);
      sel_q      <= '0;
      addr_q     <= '0;
      s_re       <= 1'b0;
`ifdef C2C_R_ARB_RSP_REG_EN
      rsp_data_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant  <= pick_idx;
            sel_q  <= pick_sel;
            addr_q <= pick_addr;
            s_re   <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (s_ack) begin
            last_grant <= grant;
            s_re       <= 1'b0;
`ifdef C2C_R_ARB_RSP_REG_EN
            rsp_data_q <= s_data;
            state      <= RESP;
`else
            state      <= IDLE;
`endif
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          s_re  <= 1'b0;
        end
      endcase
    end
  end

  // The slave only ever sees the latched copy, never live master inputs
  assign s_sel  = sel_q;
  assign s_addr = addr_q;

  // Response source: registered copy in RESP, or straight through from the slave in BUSY.
  // Reset in the same cycle suppresses the pulse.
`ifdef C2C_R_ARB_RSP_REG_EN
  assign rsp_fire = (state == RESP) && !reset;
  assign rsp_dat  = rsp_data_q;
`else
  assign rsp_fire = (state == BUSY) && s_ack && !reset;
  assign rsp_dat  = s_data;
`endif

  // Steer the response to the granted slice only; every other slice stays zero
  always_comb begin
    m_ack  = '0;
    m_data = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (rsp_fire && (GW'(i) == grant)) begin
        m_ack[i]                = 1'b1;
        m_data[i*XLEN +: XLEN]  = rsp_dat;
      end
    end
  end

endmodule

// File: tb/tb_c2c_r_arb.sv
// tb_c2c_r_arb: directed bench for the 4-port read arbiter.
// Latency: inputs driven 1 ns after the rising edge, outputs sampled 1 ns later.
// Backpressure: the bench plays the slave and acks at fixed, hand-chosen cycles.
module tb_c2c_r_arb;

  localparam int XLEN = 32;
  localparam int NP   = 4;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP-1:0]      m_re;
  logic [NP*4-1:0]    m_sel;
  logic [NP*XLEN-1:0] m_addr;
  logic [NP-1:0]      m_ack;
  logic [NP*XLEN-1:0] m_data;
  logic               s_re;
  logic [3:0]         s_sel;
  logic [XLEN-1:0]    s_addr;
  logic               s_ack;
  logic [XLEN-1:0]    s_data;

  int n_chk  = 0;
  int n_pass = 0;

  c2c_r_arb #(
    .XLEN    (XLEN),
    .N_PORTS (NP)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .m_re   (m_re),
    .m_sel  (m_sel),
    .m_addr (m_addr),
    .m_ack  (m_ack),
    .m_data (m_data),
    .s_re   (s_re),
    .s_sel  (s_sel),
    .s_addr (s_addr),
    .s_ack  (s_ack),
    .s_data (s_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic [31:0] addr, input logic [3:0] sel);
    m_addr[port*XLEN +: XLEN] = addr;
    m_sel[port*4 +: 4]        = sel;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m_re   = '0;
    s_ack  = 1'b0;
    s_data = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Called in an IDLE cycle with m_re already set; the next edge must grant 'port'
  task automatic expect_grant(input string tag, input logic [31:0] addr, input logic [3:0] sel);
    cyc();
    #1;
    chk({tag, "_s_re"}, s_re, 1);
    chk({tag, "_s_addr"}, s_addr, addr);
    chk({tag, "_s_sel"}, s_sel, sel);
  endtask

  // Called in a BUSY cycle: slave acks now, response must reach 'port' only, then one IDLE gap
  task automatic ack_xfer(input string tag, input int port, input logic [31:0] d);
    logic [127:0] ed;
    logic [3:0]   oh;
    ed = '0;
    ed[port*XLEN +: XLEN] = d;
    oh = 4'(1 << port);
    s_ack  = 1'b1;
    s_data = d;
    #1;
`ifdef C2C_R_ARB_RSP_REG_EN
    chk({tag, "_ack_early"}, m_ack, 0);
    cyc();
    s_ack  = 1'b0;
    s_data = '0;
    #1;
    chk({tag, "_resp_s_re"}, s_re, 0);
`endif
    chk({tag, "_m_ack"}, m_ack, oh);
    chk({tag, "_m_data"}, m_data, ed);
    cyc();
    s_ack  = 1'b0;
    s_data = '0;
    #1;
    chk({tag, "_ack_clr"}, m_ack, 0);
    chk({tag, "_gap_s_re"}, s_re, 0);
  endtask

  initial begin
    reset  = 1'b1;
    m_re   = '0;
    m_sel  = '0;
    m_addr = '0;
    s_ack  = 1'b0;
    s_data = '0;

    // Reset values
    cyc();
    cyc();
    #1;
    chk("rst_s_re", s_re, 0);
    chk("rst_s_sel", s_sel, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_m_ack", m_ack, 0);
    chk("rst_m_data", m_data, 0);
    cyc();
    reset = 1'b0;

    // Single request, slave acks two cycles after s_re
    set_req(0, 32'h100, 4'hF);
    m_re = 4'b0001;
    expect_grant("t1", 32'h100, 4'hF);
    chk("t1_no_early_ack", m_ack, 0);
    cyc();
    chk("t1_wait_s_re", s_re, 1);
    chk("t1_wait_m_ack", m_ack, 0);
    cyc();
    ack_xfer("t1", 0, 32'hCAFE_0001);
    m_re = '0;

    // Two masters requesting continuously: 0,1,0,1 with immediate acks
    do_reset();
    set_req(0, 32'h200, 4'h1);
    set_req(1, 32'h300, 4'h2);
    m_re = 4'b0011;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_grant($sformatf("t2_%0d", k), 32'h200, 4'h1);
      else            expect_grant($sformatf("t2_%0d", k), 32'h300, 4'h2);
      ack_xfer($sformatf("t2_%0d", k), k % 2, 32'hD000_0000 + k);
    end
    m_re = '0;

    // Four-port rotation: last grant 2, then requests 1011 give 3,0,1
    do_reset();
    set_req(2, 32'h2000, 4'h4);
    m_re = 4'b0100;
    expect_grant("t3_p2", 32'h2000, 4'h4);
    ack_xfer("t3_p2", 2, 32'h0000_2222);
    set_req(3, 32'h3000, 4'h8);
    set_req(0, 32'h1000, 4'h1);
    set_req(1, 32'h1100, 4'h2);
    m_re = 4'b1011;
    expect_grant("t3_p3", 32'h3000, 4'h8);
    ack_xfer("t3_p3", 3, 32'h0000_3333);
    expect_grant("t3_p0", 32'h1000, 4'h1);
    ack_xfer("t3_p0", 0, 32'h0000_0000 + 32'h1111);
    expect_grant("t3_p1", 32'h1100, 4'h2);
    ack_xfer("t3_p1", 1, 32'h0000_4444);
    m_re = '0;

    // Input isolation, and a master that drops re early still gets its ack
    set_req(0, 32'h400, 4'hF);
    m_re = 4'b0001;
    expect_grant("t4", 32'h400, 4'hF);
    set_req(0, 32'hDEAD_0000, 4'h3);
    m_re = '0;
    cyc();
    chk("t4_hold_s_re", s_re, 1);
    chk("t4_hold_s_addr", s_addr, 32'h400);
    chk("t4_hold_s_sel", s_sel, 4'hF);
    ack_xfer("t4", 0, 32'h0000_5555);

    // Reset while BUSY with a coincident ack, then a late ack after reset
    set_req(1, 32'h500, 4'hF);
    m_re = 4'b0010;
    expect_grant("t5", 32'h500, 4'hF);
    reset  = 1'b1;
    s_ack  = 1'b1;
    s_data = 32'h0000_6666;
    m_re   = '0;
    #1;
    chk("t5_rst_prio_m_ack", m_ack, 0);
    cyc();
    reset = 1'b0;
    s_ack = 1'b1;
    #1;
    chk("t5_after_rst_s_re", s_re, 0);
    chk("t5_late_ack_m_ack", m_ack, 0);
    chk("t5_late_ack_m_data", m_data, 0);
    cyc();
    s_ack  = 1'b0;
    s_data = '0;
    #1;
    chk("t5_settled_s_re", s_re, 0);
    chk("t5_settled_m_ack", m_ack, 0);

    // Spurious ack in IDLE, then confirm the arbiter is still idle with last grant 3
    s_ack  = 1'b1;
    s_data = 32'hFFFF_FFFF;
    #1;
    chk("t6_idle_ack_m_ack", m_ack, 0);
    chk("t6_idle_ack_m_data", m_data, 0);
    cyc();
    s_ack  = 1'b0;
    s_data = '0;
    #1;
    chk("t6_still_idle_s_re", s_re, 0);
    set_req(0, 32'h600, 4'hF);
    set_req(2, 32'h700, 4'hC);
    m_re = 4'b0101;
    expect_grant("t6_p0", 32'h600, 4'hF);
    ack_xfer("t6_p0", 0, 32'h0000_7777);
    expect_grant("t6_p2", 32'h700, 4'hC);
    ack_xfer("t6_p2", 2, 32'h0000_8888);
    m_re = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/c2c_r_arb.md
# c2c_r_arb

Parametrised N-way arbiter for the core-to-cache read channel. It multiplexes `N_PORTS` read masters onto one cache read slave using the `re`/`sel`/`addr` → `ack`/`data` handshake. Arbitration is round-robin. Each grant holds until the single outstanding read is acknowledged. It sits between the fetch/load units (and any future read masters, e.g. a page-table walker) and the L1 cache read port.

## Interface

- `XLEN`, default `pipeline::XLEN`: data/address width.
- `N_PORTS`, default 2: number of masters, ≥1.
- `GW`, default `$clog2(N_PORTS)` (min 1): grant index width. Derived; do not override.

Ports:

- `clk`  in  1  clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_re`  in  N_PORTS  per-master read request.
- `m_sel`  in  N_PORTS*XLEN/8  per-master byte selects; master i occupies slice i.
- `m_addr`  in  N_PORTS*XLEN  per-master address.
- `m_ack`  out  N_PORTS  per-master acknowledge, one-cycle pulse.
- `m_data`  out  N_PORTS*XLEN  per-master read data, valid only with the matching `m_ack` bit.
- `s_re`  out  1  slave read request.
- `s_sel`  out  XLEN/8  slave byte selects.
- `s_addr`  out  XLEN  slave address.
- `s_ack`  in  1  slave acknowledge.
- `s_data`  in  XLEN  slave read data, valid with `s_ack`.

## Operation

- Handshake rule for both sides:
  - A requester holds `re`, `sel` and `addr` stable until it sees `ack`.
  - `ack` is a one-cycle pulse.
  - A requester may re-assert `re` in the cycle after `ack`.
- FSM states: IDLE, BUSY, plus RESP when the response register is enabled.
- IDLE:
  - If any `m_re` is set, choose the first set bit searching upward from `last_grant+1`, wrapping modulo `N_PORTS`.
  - Latch the grant index, `sel` and `addr` of that master into registers, then go to BUSY.
  - If no `m_re` is set, remain in IDLE.
- BUSY:
  - `s_re`=1; `s_sel`/`s_addr` are driven from the latched registers, not live master inputs.
  - On `s_ack`: route `s_data` to slice `grant` of `m_data` and pulse `m_ack[grant]`.
  - Also on `s_ack`: set `last_grant`=`grant` and go to IDLE.
- Fairness:
  - A master that re-requests immediately loses to any other pending master.
  - With all masters continuously requesting, grants rotate 0,1,…,N_PORTS-1,0.
- `m_data` slices not being acknowledged are driven 0.
- `s_ack` while in IDLE (or RESP) is ignored and produces no `m_ack`.
- A master dropping `re` before `ack` is a protocol violation. The transaction still completes; its `ack` is delivered regardless.
- `N_PORTS`=1: the arbiter degenerates to a 1-cycle request register stage.

## Timing

- Reset values:
  - state=IDLE, `last_grant`=N_PORTS-1, so port 0 wins first.
  - `s_re`=0, `s_sel`=0, `s_addr`=0.
  - `m_ack`=0, `m_data`=0.
- Request path: `m_re` sampled at edge k; `s_re` asserted in cycle k+1.
- Response path (macro off): `m_ack`/`m_data` are combinational from `s_ack`/`s_data` in the same cycle.
- Minimum per transaction: 2 cycles (IDLE, BUSY with immediate `s_ack`). Back-to-back grants therefore have one IDLE cycle between `s_ack` and the next `s_re`.
- Reset mid-transaction: return to IDLE and drop `s_re` the next cycle. A late `s_ack` after reset is ignored.
- Reset takes priority over `s_ack` in the same cycle.

## Configuration

- `C2C_R_ARB_RSP_REG_EN` defined:
  - `s_ack` in BUSY registers `s_data` and grant, then moves to RESP.
  - RESP pulses `m_ack[grant]` with the registered data for one cycle, then goes to IDLE.
  - Adds 1 cycle of response latency and breaks the combinational `s_ack`→`m_ack` path.
  - `s_re` drops in RESP.
- Not defined: RESP does not exist; behaviour is as in Operation/Timing.

## Test plan

- Single request:
  - Stimulus: after reset, m_re=01, m_addr[0]=0x100, m_sel[0]=0xF; slave acks 2 cycles after `s_re`.
  - Response: `s_re` in cycle 1 with `s_addr`=0x100, `s_sel`=0xF; m_ack=01 and m_data[0]=`s_data` in the ack cycle, or one cycle later with the macro.
- Simultaneous requests:
  - Stimulus: m_re=11 held continuously, slave acks immediately.
  - Response: grant order 0,1,0,1; each `m_ack` is exactly one cycle; the non-granted slice of `m_data` stays 0.
- Rotation with 4 ports:
  - Stimulus: N_PORTS=4, last grant=2, m_re=1011.
  - Response: port 3 granted next, then 0, then 1.
- Input isolation:
  - Stimulus: granted master changes `m_addr` during BUSY.
  - Response: `s_addr` keeps the latched value.
- Reset and spurious ack:
  - Stimulus: reset asserted in BUSY, then `s_ack` the following cycle.
  - Response: `s_re`=0 after reset; no `m_ack` pulse.
- Ack in IDLE:
  - Stimulus: `s_ack` pulsed while IDLE with m_re=0.
  - Response: m_ack=0; state stays IDLE.
